// File: rtl/ascon_pkg.sv
// Shared constants for the Ascon AEAD controller, wrapper and datapath:
// FSM state encoding, IV construction and block-count arithmetic.
package ascon_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_PERM_INIT = 4'd2;
    localparam logic [3:0] S_KEYX      = 4'd3;
    localparam logic [3:0] S_AD_ABS    = 4'd4;
    localparam logic [3:0] S_PERM_AD   = 4'd5;
    localparam logic [3:0] S_SEP       = 4'd6;
    localparam logic [3:0] S_TXT_ABS   = 4'd7;
    localparam logic [3:0] S_PERM_TXT  = 4'd8;
    localparam logic [3:0] S_FIN_KEY   = 4'd9;
    localparam logic [3:0] S_PERM_FIN  = 4'd10;
    localparam logic [3:0] S_TAG       = 4'd11;
    localparam logic [3:0] S_DONE      = 4'd12;

    // IV = k || r || a || b || 0^32, each field one byte.
    function automatic logic [63:0] ascon_iv(int k, int r, int a, int b);
        return {8'(k), 8'(r), 8'(a), 8'(b), 32'h0};
    endfunction

    // Padding always appends a 1, so a full final block still adds one more block.
    function automatic int nad_blocks(int l, int r);
        return (l == 0) ? 0 : l / r + 1;
    endfunction

    function automatic int ntxt_blocks(int y, int r);
        return y / r + 1;
    endfunction

    function automatic logic is_perm(logic [3:0] s);
        return (s == S_PERM_INIT) || (s == S_PERM_AD) || (s == S_PERM_TXT) || (s == S_PERM_FIN);
    endfunction

endpackage

// File: rtl/ascon_aead_ctrl.sv
// Phase sequencer for the shared Ascon AEAD datapath: issues permutation
// launches and one-cycle datapath strobes from init through tag.
module ascon_aead_ctrl
    import ascon_pkg::*;
#(
    parameter int R = 64,
    parameter int A = 12,
    parameter int B = 6,
    parameter int L = 16,
    parameter int Y = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       perm_done_i,
    output logic       perm_start_o,
    output logic [3:0] perm_rounds_o,
    output logic       init_load_o,
    output logic       key_xor_o,
    output logic       ad_absorb_o,
    output logic       sep_o,
    output logic       txt_absorb_o,
    output logic       fin_key_o,
    output logic       tag_o,
    output logic [7:0] blk_idx_o,
    output logic       mode_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int NAD  = nad_blocks(L, R);
    localparam int NTXT = ntxt_blocks(Y, R);
    localparam logic [7:0] AD_LAST  = 8'((NAD > 0) ? NAD - 1 : 0);
    localparam logic [7:0] TXT_LAST = 8'(NTXT - 1);
    localparam logic [3:0] RND_A = 4'(A);
    localparam logic [3:0] RND_B = 4'(B);

    if (NAD > 255 || NTXT > 255) begin : g_bad_len
        $error("ascon_aead_ctrl: block count does not fit the 8-bit index");
    end
    if (R != 64 && R != 128) begin : g_bad_rate
        $error("ascon_aead_ctrl: rate must be 64 or 128");
    end
    if (A > 15 || B > 15) begin : g_bad_rounds
        $error("ascon_aead_ctrl: round counts must fit in 4 bits");
    end

    logic [3:0] state, state_nx;
    logic [7:0] blk_idx, blk_nx;
    logic       perm_first;
    logic       perm_ack;

    // A done pulse on the launch cycle cannot belong to our permutation.
    assign perm_ack = is_perm(state) && !perm_first && perm_done_i;

    always_comb begin
        state_nx = state;
        blk_nx   = blk_idx;
        case (state)
            S_IDLE: if (start_i) begin
                state_nx = S_INIT;
                blk_nx   = 8'd0;
            end
            S_INIT:      state_nx = S_PERM_INIT;
            S_PERM_INIT: if (perm_ack) state_nx = S_KEYX;
            S_KEYX:      state_nx = (NAD > 0) ? S_AD_ABS : S_SEP;
            S_AD_ABS:    state_nx = S_PERM_AD;
            S_PERM_AD: if (perm_ack) begin
                if (blk_idx == AD_LAST) begin
                    blk_nx   = 8'd0;
                    state_nx = S_SEP;
                end else begin
                    blk_nx   = blk_idx + 8'd1;
                    state_nx = S_AD_ABS;
                end
            end
            S_SEP: begin
                blk_nx   = 8'd0;
                state_nx = S_TXT_ABS;
            end
            S_TXT_ABS:   state_nx = (blk_idx == TXT_LAST) ? S_FIN_KEY : S_PERM_TXT;
            S_PERM_TXT: if (perm_ack) begin
                blk_nx   = blk_idx + 8'd1;
                state_nx = S_TXT_ABS;
            end
            S_FIN_KEY:   state_nx = S_PERM_FIN;
            S_PERM_FIN:  if (perm_ack) state_nx = S_TAG;
            S_TAG:       state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            blk_idx    <= 8'd0;
            mode_o     <= 1'b0;
            perm_first <= 1'b0;
        end else begin
            state      <= state_nx;
            blk_idx    <= blk_nx;
            perm_first <= (state_nx != state) && is_perm(state_nx);
            if (state == S_IDLE && start_i) mode_o <= mode_i;
        end
    end

    always_comb begin
        perm_rounds_o = 4'd0;
        case (state)
            S_PERM_INIT, S_PERM_FIN: perm_rounds_o = RND_A;
            S_PERM_AD, S_PERM_TXT:   perm_rounds_o = RND_B;
            default:                 perm_rounds_o = 4'd0;
        endcase
    end

    assign perm_start_o = is_perm(state) && perm_first;
    assign init_load_o  = (state == S_INIT);
    assign key_xor_o    = (state == S_KEYX);
    assign ad_absorb_o  = (state == S_AD_ABS);
    assign sep_o        = (state == S_SEP);
    assign txt_absorb_o = (state == S_TXT_ABS);
    assign fin_key_o    = (state == S_FIN_KEY);
    assign tag_o        = (state == S_TAG);
    assign done_o       = (state == S_DONE);
    assign busy_o       = (state != S_IDLE) && (state != S_DONE);
    assign blk_idx_o    = blk_idx;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Bench for ascon_aead_ctrl: three parameterisations, a modelled permutation
// core, an event-order reference and latency/handshake checks.
module tb_ascon_aead_ctrl;

    localparam int R    = 64;
    localparam int NCFG = 3;
    localparam int LS[NCFG] = '{16, 0, 64};
    localparam int YS[NCFG] = '{16, 200, 16};

    localparam int E_INIT = 1, E_PERM = 2, E_KEYX = 3, E_AD = 4, E_SEP = 5;
    localparam int E_TXT = 6, E_FIN = 7, E_TAG = 8, E_DONE = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_v[NCFG], mode_v[NCFG], pd_v[NCFG];
    logic       ps[NCFG], init_s[NCFG], kx[NCFG], ad[NCFG], sep[NCFG], txt[NCFG];
    logic       fin[NCFG], tag[NCFG], md[NCFG], busy[NCFG], done[NCFG];
    logic [3:0] pr[NCFG];
    logic [7:0] blk[NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        ascon_aead_ctrl #(.R(R), .A(12), .B(6), .L(LS[g]), .Y(YS[g])) u_dut (
            .clk(clk), .rst(rst), .start_i(start_v[g]), .mode_i(mode_v[g]),
            .perm_done_i(pd_v[g]), .perm_start_o(ps[g]), .perm_rounds_o(pr[g]),
            .init_load_o(init_s[g]), .key_xor_o(kx[g]), .ad_absorb_o(ad[g]),
            .sep_o(sep[g]), .txt_absorb_o(txt[g]), .fin_key_o(fin[g]), .tag_o(tag[g]),
            .blk_idx_o(blk[g]), .mode_o(md[g]), .busy_o(busy[g]), .done_o(done[g])
        );
    end

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int obs_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ow(input int g);
        return int'({ps[g], pr[g], init_s[g], kx[g], ad[g], sep[g], txt[g], fin[g], tag[g],
                     blk[g], md[g], busy[g], done[g]});
    endfunction

    function automatic int sw(input int g);
        return int'({ps[g], pr[g], init_s[g], kx[g], ad[g], sep[g], txt[g], fin[g], tag[g],
                     busy[g], done[g]});
    endfunction

    // Reference order of datapath events for one operation.
    task automatic build_exp(input int nad, input int ntxt);
        exp_q.delete();
        exp_q.push_back(E_INIT * 1000);
        exp_q.push_back(E_PERM * 1000 + 12);
        exp_q.push_back(E_KEYX * 1000);
        for (int i = 0; i < nad; i++) begin
            exp_q.push_back(E_AD * 1000 + i);
            exp_q.push_back(E_PERM * 1000 + 6);
        end
        exp_q.push_back(E_SEP * 1000);
        for (int i = 0; i < ntxt; i++) begin
            exp_q.push_back(E_TXT * 1000 + i);
            if (i < ntxt - 1) exp_q.push_back(E_PERM * 1000 + 6);
        end
        exp_q.push_back(E_FIN * 1000);
        exp_q.push_back(E_PERM * 1000 + 12);
        exp_q.push_back(E_TAG * 1000);
        exp_q.push_back(E_DONE * 1000);
    endtask

    function automatic int lat_model(input int nad, input int ntxt, input int p);
        return 1 + (p + 1) + 1 + nad * (p + 2) + 1 + ntxt + (ntxt - 1) * (p + 1) + 1 + (p + 1) + 1 + 1;
    endfunction

    // One operation on instance g. The bench core returns done p cycles after
    // each launch; spur is the percentage of idle/launch cycles carrying a stray done.
    task automatic run_op(input int g, input bit m, input int p, input bit hold, input int spur,
                          input int lat, input string name, input bit abort);
        int st, held, viol, busy_n, done_c, ad_c, nad, ntxt, first, n;
        bit pending;
        nad  = (LS[g] == 0) ? 0 : LS[g] / R + 1;
        ntxt = YS[g] / R + 1;
        build_exp(nad, ntxt);
        obs_q.delete();
        pending = 0; viol = 0; busy_n = 0; done_c = -1; st = 0; held = 0; ad_c = -1;
        start_v[g] = 1'b1;
        mode_v[g]  = m;
        for (int c = 1; c <= 2000 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (!hold) start_v[g] = 1'b0;
            mode_v[g] = 1'($urandom);
            if ($countones({ps[g], init_s[g], kx[g], ad[g], sep[g], txt[g], fin[g], tag[g], done[g]}) > 1)
                viol++;
            if (busy[g]) busy_n++;
            if (ps[g]) begin
                obs_q.push_back(E_PERM * 1000 + int'(pr[g]));
                pending = 1; st = c; held = int'(pr[g]);
            end else if (pending && int'(pr[g]) != held) viol++;
            if (init_s[g]) obs_q.push_back(E_INIT * 1000);
            if (kx[g])     obs_q.push_back(E_KEYX * 1000);
            if (ad[g]) begin
                obs_q.push_back(E_AD * 1000 + int'(blk[g]));
                ad_c = c;
            end
            if (sep[g])    obs_q.push_back(E_SEP * 1000);
            if (txt[g])    obs_q.push_back(E_TXT * 1000 + int'(blk[g]));
            if (fin[g])    obs_q.push_back(E_FIN * 1000);
            if (tag[g])    obs_q.push_back(E_TAG * 1000);
            if (done[g]) begin
                obs_q.push_back(E_DONE * 1000);
                done_c = c;
                chk({name, "_mode"}, int'(md[g]), int'(m));
            end
            if (abort && ad_c > 0 && c == ad_c + 2) begin
                pd_v[g] = 1'b0;
                rst = 1'b0;
                return;
            end
            pd_v[g] = (pending && c == st + p) ||
                      (spur > 0 && (!pending || c == st) && int'($urandom_range(0, 99)) < spur);
            if (pending && c == st + p) pending = 0;
        end
        chk({name, "_latency"}, done_c, lat);
        chk({name, "_busy_cycles"}, busy_n, lat - 1);
        chk({name, "_strobe_overlap"}, viol, 0);
        chk({name, "_seq_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        first = -1;
        for (int i = 0; i < n; i++)
            if (first < 0 && obs_q[i] != exp_q[i]) first = i;
        chk({name, "_seq_event"}, (first >= 0) ? obs_q[first] : 0, (first >= 0) ? exp_q[first] : 0);
        // After DONE: back in IDLE and no restart, even if start was held through DONE.
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        pd_v[g]    = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (sw(g) != 0) n++;
            @(posedge clk); #1;
        end
        chk({name, "_idle_after"}, n, 0);
    endtask

    typedef struct {
        int    g;
        bit    m;
        int    p;
        bit    hold;
        int    spur;
        int    lat;
        string name;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n;
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            start_v[g] = 1'b0; mode_v[g] = 1'b0; pd_v[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) chk($sformatf("reset_out%0d", g), ow(g), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        vt[0] = '{0, 1'b0, 6, 1'b0,   0, 29, "dflt_enc"};
        vt[1] = '{1, 1'b1, 6, 1'b0,   0, 45, "noad_dec"};
        vt[2] = '{0, 1'b1, 6, 1'b1,   0, 29, "start_held"};
        vt[3] = '{0, 1'b0, 6, 1'b0, 100, 29, "spurious_done"};
        vt[4] = '{2, 1'b0, 6, 1'b0,   0, 37, "ad_full_blk"};
        vt[5] = '{1, 1'b0, 2, 1'b1, 100, 25, "noad_p2_held"};
        vt[6] = '{2, 1'b1, 1, 1'b0, 100, 17, "ad_full_p1"};
        vt[7] = '{0, 1'b0, 3, 1'b0,   0, 20, "dflt_p3"};
        for (int i = 0; i < 8; i++)
            run_op(vt[i].g, vt[i].m, vt[i].p, vt[i].hold, vt[i].spur, vt[i].lat, vt[i].name, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int g, p, nad, ntxt;
            g    = int'($urandom_range(0, NCFG - 1));
            p    = int'($urandom_range(1, 8));
            nad  = (LS[g] == 0) ? 0 : LS[g] / R + 1;
            ntxt = YS[g] / R + 1;
            run_op(g, 1'($urandom), p, 1'($urandom), int'($urandom_range(0, 60)),
                   lat_model(nad, ntxt, p), $sformatf("rand%0d", i), 1'b0);
        end

        // Abort inside PERM_AD; the late done after release must be ignored.
        run_op(0, 1'b1, 6, 1'b0, 0, 29, "abort", 1'b1);
        @(posedge clk); #1;
        chk("rst_mid_op_out", ow(0), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_out", ow(0), 0);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            pd_v[0] = (k == 1);
            @(posedge clk); #1;
            if (ow(0) != 0) n++;
        end
        pd_v[0] = 1'b0;
        chk("rst_late_done_ignored", n, 0);
        run_op(0, 1'b0, 6, 1'b0, 0, 29, "post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
